// File: rtl/spart_rx_baud_ctrl.sv
// SPART receive baud sequencer: synchronises rxd, detects start bits and issues ten
// mid-bit receive_baud strobes per frame, with a programmable divisor and sticky errors.
module spart_rx_baud_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter logic [15:0] MIN_DIV     = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        rx_en,
  input  logic        db_wr_lo,
  input  logic        db_wr_hi,
  input  logic [7:0]  db_wdata,
  input  logic        rda,
  input  logic        err_clr,
  output logic        receive_baud,
  output logic        busy,
  output logic        start_err,
  output logic        frame_err,
  output logic        overrun,
  output logic [15:0] divisor
);

  // state | meaning
  // IDLE  | line idle, waiting for rx_s low while rx_en is set
  // HALF  | counting half a bit to the middle of the start bit
  // BITS  | counting whole bits, strobing D0-D7 and the stop bit
  // GUARD | frame done, waiting for the line to return high
  typedef enum logic [1:0] {IDLE, HALF, BITS, GUARD} state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s;
  logic [15:0] div_eff;
  logic [15:0] shadow, shadow_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  pcnt, pcnt_n;
  logic        baud_n, start_set, frame_set, ovr_set;

  always_comb div_eff = (divisor < MIN_DIV) ? MIN_DIV : divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DEFAULT_DIV;
    end else begin
      if (db_wr_lo) divisor[7:0]  <= db_wdata;
      if (db_wr_hi) divisor[15:8] <= db_wdata;
    end
  end

  // The strobe is registered, so it is requested one count early (cnt==2) to be
  // high exactly in the cycle where cnt==1 and the line is sampled.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pcnt_n    = pcnt;
    shadow_n  = shadow;
    baud_n    = 1'b0;
    start_set = 1'b0;
    frame_set = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en && !rx_s) begin
          shadow_n = div_eff;
          cnt_n    = {1'b0, div_eff[15:1]};
          pcnt_n   = 4'd0;
          state_n  = HALF;
        end
      end
      HALF: begin
        cnt_n = cnt - 16'd1;
        if (cnt == 16'd2) baud_n = 1'b1;
        if (cnt == 16'd1) begin
          start_set = rx_s;
          cnt_n     = shadow;
          pcnt_n    = 4'd1;
          state_n   = BITS;
        end
      end
      BITS: begin
        cnt_n = cnt - 16'd1;
        if (cnt == 16'd2) baud_n = 1'b1;
        if (cnt == 16'd1) begin
          pcnt_n = pcnt + 4'd1;
          if (pcnt == 4'd9) begin
            frame_set = !rx_s;
            ovr_set   = rda;
            state_n   = GUARD;
          end else begin
            cnt_n = shadow;
          end
        end
      end
      GUARD: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      pcnt         <= 4'd0;
      shadow       <= DEFAULT_DIV;
      receive_baud <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pcnt         <= pcnt_n;
      shadow       <= shadow_n;
      receive_baud <= baud_n;
      busy         <= (state_n != IDLE);
    end
  end

  // err_clr wins over a set arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_err <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (err_clr) begin
      start_err <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      start_err <= start_err | start_set;
      frame_err <= frame_err | frame_set;
      overrun   <= overrun | ovr_set;
    end
  end

endmodule

// File: tb/tb_spart_rx_baud_ctrl.sv
// Bench for spart_rx_baud_ctrl: strobe timing predicted arithmetically from the start
// edge, error flags predicted from the recorded line at the predicted sample points.
module tb_spart_rx_baud_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        rx_en = 1'b1;
  logic        db_wr_lo = 1'b0;
  logic        db_wr_hi = 1'b0;
  logic [7:0]  db_wdata = 8'h00;
  logic        rda = 1'b0;
  logic        err_clr = 1'b0;
  logic        receive_baud, busy, start_err, frame_err, overrun;
  logic [15:0] divisor;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes[$];
  bit line  [0:65535];
  bit rda_h [0:65535];
  bit m_start, m_frame, m_ovr;

  spart_rx_baud_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_en(rx_en),
    .db_wr_lo(db_wr_lo), .db_wr_hi(db_wr_hi), .db_wdata(db_wdata),
    .rda(rda), .err_clr(err_clr), .receive_baud(receive_baud), .busy(busy),
    .start_err(start_err), .frame_err(frame_err), .overrun(overrun), .divisor(divisor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record what the line and rda looked like in each cycle, and when strobes occurred
  always @(negedge clk) begin
    if (cyc < 65536) begin
      line[cyc]  = rxd;
      rda_h[cyc] = rda;
    end
    if (receive_baud === 1'b1) strobes.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr_div(input logic [15:0] v);
    db_wr_lo = 1'b1; db_wdata = v[7:0];
    tick();
    db_wr_lo = 1'b0; db_wr_hi = 1'b1; db_wdata = v[15:8];
    tick();
    db_wr_hi = 1'b0;
    tick();
    chk("div_readback", divisor, v);
  endtask

  // Drives one 8N1 frame with bit width eff; optionally rewrites the divisor during D3.
  task automatic send_frame(input logic [7:0] data, input bit stop, input int eff,
                            input int mid_wr, output int c);
    logic [9:0] fr;
    logic [15:0] w;
    fr = {stop, data, 1'b0};
    w  = mid_wr[15:0];
    c  = cyc;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < eff; j++) begin
        rxd = fr[b];
        db_wr_lo = 1'b0; db_wr_hi = 1'b0;
        if (mid_wr >= 0 && b == 4 && j == 0) begin
          db_wr_lo = 1'b1; db_wdata = w[7:0];
        end else if (mid_wr >= 0 && b == 4 && j == 1) begin
          db_wr_hi = 1'b1; db_wdata = w[15:8];
        end
        tick();
      end
    end
    db_wr_lo = 1'b0; db_wr_hi = 1'b0;
  endtask

  // Start edge driven in cycle c reaches rx_s two cycles later; strobe k follows
  // half a bit after that and then every eff cycles.
  task automatic check_frame(input int c, input int eff);
    int h, te, t, waited, t1, t10;
    h = eff / 2;
    waited = 0;
    while (strobes.size() < 10 && waited < 12 * eff + 50) begin
      tick();
      waited++;
    end
    chk("strobe_count", (strobes.size() >= 10), 1'b1);
    for (int k = 1; k <= 10; k++) begin
      te = c + 2 + h + (k - 1) * eff;
      t = -1;
      if (strobes.size() > 0) t = strobes.pop_front();
      chk($sformatf("strobe_time_k%0d", k), t, te);
    end
    t1  = c + 2 + h;
    t10 = c + 2 + h + 9 * eff;
    if (line[t1 - 2]) m_start = 1'b1;
    if (!line[t10 - 2]) m_frame = 1'b1;
    if (rda_h[t10]) m_ovr = 1'b1;
  endtask

  task automatic chk_flags();
    tick(); tick();
    chk("start_err", start_err, m_start);
    chk("frame_err", frame_err, m_frame);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (busy !== 1'b0 && waited < 100) begin
      tick();
      waited++;
    end
    chk("busy_idle", busy, 1'b0);
    tick(); tick();
    chk("no_extra_strobes", strobes.size(), 0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_start = 1'b0; m_frame = 1'b0; m_ovr = 1'b0;
    chk_flags();
  endtask

  initial begin
    int c, c2, prog, eff;
    logic [7:0] data;
    m_start = 1'b0; m_frame = 1'b0; m_ovr = 1'b0;

    // Reset state and a long idle line
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_divisor", divisor, 16'd434);
    chk("rst_busy", busy, 1'b0);
    chk("rst_baud", receive_baud, 1'b0);
    chk_flags();
    repeat (1000) tick();
    chk("idle_strobes", strobes.size(), 0);

    // Detection disarmed: a low line is ignored
    rx_en = 1'b0; rxd = 1'b0;
    repeat (50) tick();
    rxd = 1'b1;
    repeat (4) tick();
    chk("rx_en_off_strobes", strobes.size(), 0);
    chk("rx_en_off_busy", busy, 1'b0);
    rx_en = 1'b1;

    // Simultaneous byte writes load both halves
    db_wr_lo = 1'b1; db_wr_hi = 1'b1; db_wdata = 8'h12;
    tick();
    db_wr_lo = 1'b0; db_wr_hi = 1'b0;
    tick();
    chk("div_both_bytes", divisor, 16'h1212);

    // 0xA5 at divisor 16
    wr_div(16'd16);
    send_frame(8'hA5, 1'b1, 16, -1, c);
    check_frame(c, 16);
    wait_idle();
    chk_flags();

    // Random divisors (including ones below the clamp) and random data
    for (int i = 0; i < 5; i++) begin
      prog = $urandom_range(40, 0);
      eff  = (prog < 4) ? 4 : prog;
      data = 8'($urandom);
      wr_div(16'(prog));
      send_frame(data, 1'b1, eff, -1, c);
      check_frame(c, eff);
      wait_idle();
      chk_flags();
    end

    // Three-cycle glitch: start bit samples high, full frame still runs
    wr_div(16'd16);
    c = cyc;
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    check_frame(c, 16);
    wait_idle();
    chk_flags();
    clear_errs();

    // Low stop bit then a held break: stays busy until the line returns high
    send_frame(8'h3C, 1'b0, 16, -1, c);
    check_frame(c, 16);
    repeat (100) tick();
    chk("guard_hold_busy", busy, 1'b1);
    rxd = 1'b1;
    wait_idle();
    chk_flags();
    send_frame(8'h5A, 1'b1, 16, -1, c);
    check_frame(c, 16);
    wait_idle();
    clear_errs();

    // Back-to-back frames, rda raised only after the first frame completed
    rda = 1'b0;
    send_frame(8'h11, 1'b1, 16, -1, c);
    chk("overrun_after_f1", overrun, 1'b0);
    rda = 1'b1;
    send_frame(8'h22, 1'b1, 16, -1, c2);
    check_frame(c, 16);
    check_frame(c2, 16);
    rda = 1'b0;
    wait_idle();
    chk_flags();
    clear_errs();

    // Clamped divisor of 2 runs at 4
    wr_div(16'd2);
    send_frame(8'hC3, 1'b1, 4, -1, c);
    check_frame(c, 4);
    wait_idle();

    // Mid-frame divisor write: readback now, timing next frame
    wr_div(16'd16);
    send_frame(8'h96, 1'b1, 16, 20, c);
    chk("div_mid_readback", divisor, 16'd20);
    check_frame(c, 16);
    wait_idle();
    send_frame(8'h69, 1'b1, 20, -1, c);
    check_frame(c, 20);
    wait_idle();
    chk_flags();

    // Async reset mid-frame aborts the frame
    rxd = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_baud", receive_baud, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    strobes.delete();
    rxd = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (200) tick();
    chk("rst_mid_no_strobes", strobes.size(), 0);
    chk("rst_mid_divisor", divisor, 16'd434);
    m_start = 1'b0; m_frame = 1'b0; m_ovr = 1'b0;
    chk_flags();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
